// File: rtl/mul2_seq_ctrl.sv
// mul2_seq_ctrl: sequences a (2*DIGITS)x(2*DIGITS)-bit unsigned multiply through
// one shared external 2x2 combinational multiplier cell, one digit pair per cycle.
// Optional build macro: MUL2_SEQ_ZERO_SKIP_EN (a zero operand bypasses RUN).
module mul2_seq_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DIGITS-1:0] op_x,
  input  logic [2*DIGITS-1:0] op_y,
  output logic [1:0]        mul_a,
  output logic [1:0]        mul_b,
  input  logic [3:0]        mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic              busy
);
  localparam int W  = 2 * DIGITS;
  localparam int RW = 2 * W;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [1:0]    state;
  logic [W-1:0]  x_q, y_q;
  logic [IW-1:0] i_q, j_q;
  logic [RW-1:0] acc, result_q;
  logic          run;
  logic [IW:0]   dsum;
  logic [RW-1:0] pp;

  assign run       = (state == S_RUN);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = run || (state == S_DONE);
  assign result    = result_q;

  // Cell operands come straight from the registered digits; parked at 0 outside RUN.
  assign mul_a = run ? x_q[{i_q, 1'b0} +: 2] : 2'b00;
  assign mul_b = run ? y_q[{j_q, 1'b0} +: 2] : 2'b00;

  // Partial product weighted by 4^(i+j).
  assign dsum = {1'b0, i_q} + {1'b0, j_q};
  assign pp   = RW'(mul_p) << {dsum, 1'b0};

  // Control FSM, digit walk (j fastest) and shift-accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q <= op_x;
            y_q <= op_y;
            acc <= '0;
            i_q <= '0;
            j_q <= '0;
`ifdef MUL2_SEQ_ZERO_SKIP_EN
            if ((op_x == '0) || (op_y == '0)) begin
              result_q <= '0;
              state    <= S_DONE;
            end else begin
              state    <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc <= acc + pp;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              result_q <= acc + pp;
              state    <= S_DONE;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul2_seq_ctrl.sv
// Directed bench for mul2_seq_ctrl at DIGITS=2 and DIGITS=3, with a behavioural
// 2x2 multiplier cell closing the loop on each instance.
module tb_mul2_seq_ctrl;
  logic clk, rst_n;

  logic       v2, rdy2, ov2, or2, busy2;
  logic [3:0] x2, y2, p2;
  logic [1:0] a2, b2;
  logic [7:0] r2;

  logic        v3, rdy3, ov3, or3, busy3;
  logic [5:0]  x3, y3;
  logic [3:0]  p3;
  logic [1:0]  a3, b3;
  logic [11:0] r3;

  int checks = 0;
  int errors = 0;

  assign p2 = {2'b00, a2} * {2'b00, b2};
  assign p3 = {2'b00, a3} * {2'b00, b3};

  mul2_seq_ctrl #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .op_x(x2), .op_y(y2),
    .mul_a(a2), .mul_b(b2), .mul_p(p2), .out_valid(ov2), .out_ready(or2),
    .result(r2), .busy(busy2));

  mul2_seq_ctrl #(.DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .op_x(x3), .op_y(y3),
    .mul_a(a3), .mul_b(b3), .mul_p(p3), .out_valid(ov3), .out_ready(or3),
    .result(r3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_v2(output int n);
    n = 0;
    while (!ov2 && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_v3(output int n);
    n = 0;
    while (!ov3 && n < 50) begin tick(); n++; end
  endtask

  int n;
  logic [1:0] ea [4];
  logic [1:0] eb [4];

  initial begin
    rst_n = 1'b0;
    v2 = 0; x2 = 0; y2 = 0; or2 = 0;
    v3 = 0; x3 = 0; y3 = 0; or3 = 0;
    ea[0] = 2; ea[1] = 2; ea[2] = 2; ea[3] = 2;
    eb[0] = 2; eb[1] = 1; eb[2] = 2; eb[3] = 1;

    // Reset values before any clock edge
    #3;
    chk("rst_in_ready", rdy2, 1);
    chk("rst_out_valid", ov2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_result", r2, 0);
    chk("rst_mul_ab", {a2, b2}, 0);
    chk("rst_in_ready3", rdy3, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 15 x 15
    v2 = 1; x2 = 4'hF; y2 = 4'hF; or2 = 1;
    tick();
    v2 = 0;
    chk("ff_busy", busy2, 1);
    chk("ff_in_ready_run", rdy2, 0);
    wait_v2(n);
    chk("ff_latency", n, 4);
    chk("ff_result", r2, 8'hE1);
    tick();
    chk("ff_pulse", ov2, 0);
    chk("ff_in_ready_after", rdy2, 1);

    // 10 x 6 with digit order check, held in DONE by backpressure
    or2 = 0;
    v2 = 1; x2 = 4'hA; y2 = 4'h6;
    tick();
    v2 = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("a6_mul_a%0d", k), a2, ea[k]);
      chk($sformatf("a6_mul_b%0d", k), b2, eb[k]);
      tick();
    end
    chk("a6_valid", ov2, 1);
    chk("a6_result", r2, 8'h3C);
    chk("a6_mul_idle", {a2, b2}, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin v2 = 1; x2 = 4'h1; y2 = 4'h1; end
      if (k == 4) v2 = 0;
      tick();
      chk($sformatf("bp_valid%0d", k), ov2, 1);
      chk($sformatf("bp_result%0d", k), r2, 8'h3C);
      chk($sformatf("bp_in_ready%0d", k), rdy2, 0);
    end
    or2 = 1;
    tick();
    chk("bp_release_in_ready", rdy2, 1);
    chk("bp_release_valid", ov2, 0);
    chk("bp_kept_result", r2, 8'h3C);
    tick();
    chk("bp_no_new_op", busy2, 0);

    // Reset during the second RUN cycle, then a clean 3 x 5
    v2 = 1; x2 = 4'hF; y2 = 4'hF;
    tick();
    v2 = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", rdy2, 1);
    chk("mrst_valid", ov2, 0);
    chk("mrst_busy", busy2, 0);
    chk("mrst_result", r2, 0);
    chk("mrst_mul_ab", {a2, b2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("mrst_no_partial", ov2, 0);
    v2 = 1; x2 = 4'h3; y2 = 4'h5;
    tick();
    v2 = 0;
    wait_v2(n);
    chk("x35_latency", n, 4);
    chk("x35_result", r2, 8'h0F);
    tick();

    // DIGITS=3: 63 x 63
    or3 = 1;
    v3 = 1; x3 = 6'h3F; y3 = 6'h3F;
    tick();
    v3 = 0;
    wait_v3(n);
    chk("d3_latency", n, 9);
    chk("d3_result", r3, 12'hF81);
    tick();
    chk("d3_pulse", ov3, 0);

    // DIGITS=3: 0 x 9
    v3 = 1; x3 = 6'h0; y3 = 6'h9;
    tick();
    v3 = 0;
    chk("z_mul_a", a3, 0);
    wait_v3(n);
`ifdef MUL2_SEQ_ZERO_SKIP_EN
    chk("z_latency", n, 0);
`else
    chk("z_latency", n, 9);
`endif
    chk("z_valid", ov3, 1);
    chk("z_result", r3, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
